// File: rtl/ascon_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : ascon_fsm
//  Purpose  : Control sequencer for an ASCON-128 style encryption datapath.
//             Steps the datapath through initialisation, optional
//             associated-data absorption, NB_BLOCKS plaintext blocks and
//             finalisation. It drives the round index, state-register enable
//             and the rate/capacity XOR injections.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Build option:
//    ASCON_FSM_AD_EN  - when defined, one associated-data block is absorbed
//                       through WAIT_AD/AD before the plaintext phase.
//                       When undefined, the AD phase is skipped.
// ----------------------------------------------------------------------------
//  Ports:
//    clock_i          in   1   rising-edge clock
//    resetb_i         in   1   asynchronous active-low reset
//    start_i          in   1   begin one encryption (sampled in IDLE only)
//    key_i            in 128   key K, stable from start until tag_valid_o
//    data_i           in  64   current AD / plaintext block
//    data_valid_i     in   1   data_i holds a valid block
//    data_ready_o     out  1   block accepted when ready && valid
//    round_o          out  4   round index to the datapath
//    input_select_o   out  1   load initial state (INIT round 0)
//    ena_xor_up_o     out  1   XOR data_xor_up_o into rate word x0
//    ena_xor_down_o   out  1   XOR data_xor_down_o into capacity x1..x4
//    ena_reg_state_o  out  1   a permutation round executes this cycle
//    data_xor_up_o    out 64   rate XOR value
//    data_xor_down_o  out 256  capacity XOR value (x1 in bits 255:192)
//    cipher_valid_o   out  1   strobe: ciphertext block available
//    tag_valid_o      out  1   strobe: tag available
//    busy_o           out  1   sequencer not idle
// ============================================================================
module ascon_fsm #(
    parameter int NB_BLOCKS = 4
) (
    input  logic           clock_i,
    input  logic           resetb_i,
    input  logic           start_i,
    input  logic [127:0]   key_i,
    input  logic [63:0]    data_i,
    input  logic           data_valid_i,
    output logic           data_ready_o,
    output logic [3:0]     round_o,
    output logic           input_select_o,
    output logic           ena_xor_up_o,
    output logic           ena_xor_down_o,
    output logic           ena_reg_state_o,
    output logic [63:0]    data_xor_up_o,
    output logic [255:0]   data_xor_down_o,
    output logic           cipher_valid_o,
    output logic           tag_valid_o,
    output logic           busy_o
);

`ifdef ASCON_FSM_AD_EN
    localparam logic AD_EN = 1'b1;
`else
    localparam logic AD_EN = 1'b0;
`endif

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] INIT    = 3'd1;
    localparam logic [2:0] WAIT_AD = 3'd2;
    localparam logic [2:0] AD      = 3'd3;
    localparam logic [2:0] WAIT_PT = 3'd4;
    localparam logic [2:0] PT      = 3'd5;
    localparam logic [2:0] FINAL   = 3'd6;
    localparam logic [2:0] DONE    = 3'd7;

    localparam logic [3:0] LAST_ROUND = 4'd11;
    // Block counter value while the final plaintext block is awaited.
    localparam logic [3:0] LAST_IDX   = 4'(NB_BLOCKS - 1);

    logic [2:0] state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [3:0] blk_q,   blk_d;

    logic       w_accept;
    logic       w_last_blk;
    logic       w_round11;
    logic [3:0] w_wait_round;

    assign w_accept   = ((state_q == WAIT_AD) || (state_q == WAIT_PT)) && data_valid_i;
    assign w_last_blk = (blk_q == LAST_IDX);
    assign w_round11  = (round_q == LAST_ROUND);
    // On entering WAIT_PT the round index is pre-set to the round that runs in
    // the acceptance cycle: 6 for an ordinary block, 0 for the last block,
    // whose acceptance starts the 12-round finalisation permutation.
    assign w_wait_round = w_last_blk ? 4'd0 : 4'd6;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        blk_d   = blk_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = INIT;
                    round_d = 4'd0;
                    blk_d   = 4'd0;
                end
            end
            INIT: begin
                if (w_round11) begin
                    if (AD_EN) begin
                        state_d = WAIT_AD;
                        round_d = 4'd6;
                    end else begin
                        state_d = WAIT_PT;
                        round_d = w_wait_round;
                    end
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            WAIT_AD: begin
                if (data_valid_i) begin
                    state_d = AD;
                    round_d = 4'd7;
                end
            end
            AD: begin
                if (w_round11) begin
                    state_d = WAIT_PT;
                    round_d = w_wait_round;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            WAIT_PT: begin
                if (data_valid_i) begin
                    blk_d = blk_q + 4'd1;
                    if (w_last_blk) begin
                        state_d = FINAL;
                        round_d = 4'd1;
                    end else begin
                        state_d = PT;
                        round_d = 4'd7;
                    end
                end
            end
            PT: begin
                if (w_round11) begin
                    state_d = WAIT_PT;
                    round_d = w_wait_round;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            FINAL: begin
                if (w_round11) begin
                    state_d = DONE;
                    round_d = 4'd0;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                round_d = 4'd0;
                blk_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                round_d = 4'd0;
                blk_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            blk_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            blk_q   <= blk_d;
        end
    end

    // ------------------------------------------------------------------
    // Capacity XOR: every round-11 cycle enables the injection; the value
    // is the XOR of whichever key / domain-separation terms apply there.
    // ------------------------------------------------------------------
    always_comb begin
        ena_xor_down_o  = 1'b0;
        data_xor_down_o = 256'h0;
        if (w_round11) begin
            case (state_q)
                INIT: begin
                    ena_xor_down_o  = 1'b1;
                    data_xor_down_o = {128'h0, key_i};
                    if (!AD_EN) begin
                        data_xor_down_o = data_xor_down_o ^ 256'h1;
                        if (LAST_IDX == 4'd0) begin
                            data_xor_down_o = data_xor_down_o ^ {key_i, 128'h0};
                        end
                    end
                end
                AD: begin
                    ena_xor_down_o  = 1'b1;
                    data_xor_down_o = 256'h1;
                    if (LAST_IDX == 4'd0) begin
                        data_xor_down_o = data_xor_down_o ^ {key_i, 128'h0};
                    end
                end
                PT: begin
                    ena_xor_down_o = 1'b1;
                    // blk_q already counts the block just absorbed
                    if (w_last_blk) begin
                        data_xor_down_o = {key_i, 128'h0};
                    end
                end
                FINAL: begin
                    ena_xor_down_o  = 1'b1;
                    data_xor_down_o = {128'h0, key_i};
                end
                default: begin
                    ena_xor_down_o  = 1'b0;
                    data_xor_down_o = 256'h0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Remaining outputs decode directly from state, so reset clears them
    // in the same instant the state register is cleared.
    // ------------------------------------------------------------------
    assign data_ready_o    = (state_q == WAIT_AD) || (state_q == WAIT_PT);
    assign round_o         = round_q;
    assign input_select_o  = (state_q == INIT) && (round_q == 4'd0);
    assign ena_xor_up_o    = w_accept;
    assign data_xor_up_o   = w_accept ? data_i : 64'h0;
    assign ena_reg_state_o = (state_q == INIT) || (state_q == AD) || (state_q == PT) ||
                             (state_q == FINAL) || w_accept;
    assign cipher_valid_o  = (state_q == WAIT_PT) && data_valid_i;
    assign tag_valid_o     = (state_q == DONE);
    assign busy_o          = (state_q != IDLE);

endmodule
`default_nettype wire

// File: doc/ascon_fsm.md
ASCON_FSM -- requirements
Module: ascon_fsm

Interface
REQ-001 SHALL have parameter NB_BLOCKS, default 4: plaintext blocks per message, legal range 1..15.
REQ-002 SHALL have port clock_i, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetb_i, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port start_i, input, 1: begin one encryption; sampled only in IDLE.
REQ-005 SHALL have port key_i, input, 128: key K; held stable from start_i until tag_valid_o.
REQ-006 SHALL have port data_i, input, 64: current AD or plaintext block.
REQ-007 SHALL have port data_valid_i, input, 1: data_i holds a valid block.
REQ-008 SHALL have port data_ready_o, output, 1: block accepted when data_ready_o && data_valid_i.
REQ-009 SHALL have port round_o, output, 4: round index to the datapath.
REQ-010 SHALL have ports input_select_o, ena_xor_up_o, ena_xor_down_o and ena_reg_state_o, output, 1 each: datapath controls.
REQ-011 SHALL have port data_xor_up_o, output, 64: rate-word XOR value (x0).
REQ-012 SHALL have port data_xor_down_o, output, 256: capacity XOR value (x1..x4, x1 in bits 255:192).
REQ-013 SHALL have ports cipher_valid_o and tag_valid_o, output, 1 each: one-cycle strobes.
REQ-014 SHALL have port busy_o, output, 1: high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL and DONE, with a 4-bit round counter and a plaintext block counter.
REQ-016 SHALL set ena_reg_state_o=1 in exactly the cycles that execute a round (one round per cycle), and 0 elsewhere.
REQ-017 SHALL go IDLE->INIT on start_i; start_i outside IDLE is ignored.
REQ-018 SHALL run INIT as 12 cycles with round_o 0..11 and input_select_o=1 only at round 0, then go to WAIT_AD (ASCON_FSM_AD_EN) or WAIT_PT.
REQ-019 SHALL, in WAIT_AD and WAIT_PT, assert data_ready_o; with no valid data, no round executes and the state holds.
REQ-020 SHALL, on acceptance in WAIT_AD or in WAIT_PT for a non-last block, execute round 6 in that cycle with ena_xor_up_o=1 and data_xor_up_o=data_i, then rounds 7..11 in AD/PT.
REQ-021 SHALL, on acceptance of the last plaintext block (count NB_BLOCKS), execute round 0 with the xor_up in that cycle, then rounds 1..11 in FINAL.
REQ-022 SHALL pulse cipher_valid_o in every plaintext acceptance cycle.
REQ-023 SHALL, in the round-11 cycle of any permutation, set ena_xor_down_o=1 and data_xor_down_o to the XOR of every applicable term, with ena_xor_down_o=0 and data_xor_down_o=0 otherwise. Terms: INIT round 11 gives {128'h0,K}; the last permutation before the first plaintext block gives 256'h1; the permutation before the last plaintext block gives {K,128'h0}; FINAL round 11 gives {128'h0,K}.
REQ-024 SHALL go FINAL round 11 -> DONE, pulse tag_valid_o for the single DONE cycle, then return to IDLE.
REQ-025 SHALL hold data_ready_o=0 whenever a round executes outside the WAIT states; data_valid_i is ignored then.
REQ-026 SHALL produce tag_valid_o 12+6*(NB_BLOCKS-1)+12+1 cycles after start_i with no AD and zero wait cycles, plus 6 cycles with AD.

Reset
REQ-027 SHALL, on resetb_i low at any time including mid-operation, enter IDLE and clear both counters and all outputs to 0.
REQ-028 SHALL resume operation on the first rising edge after reset deassertion; a partial message is discarded.

Configuration
REQ-029 SHALL, with ASCON_FSM_AD_EN defined, process exactly one associated-data block through WAIT_AD/AD and apply the 256'h1 term at AD round 11.
REQ-030 SHALL, with ASCON_FSM_AD_EN undefined, omit WAIT_AD/AD and apply the 256'h1 term at INIT round 11.

Verification
REQ-031 SHALL cover: reset, then start_i at cycle 0 with AD enabled, NB_BLOCKS=4, data_valid_i=1 -> INIT cycles 1-12, AD 13-18, PT 19-36, FINAL 37-48, tag_valid_o at cycle 49.
REQ-032 SHALL cover: K=128'h000102..0F, INIT round 11 -> data_xor_down_o=128'h0||K, ena_xor_down_o=1.
REQ-033 SHALL cover: NB_BLOCKS=1 with AD disabled -> INIT round-11 data_xor_down_o = {K, K^128'h1}.
REQ-034 SHALL cover: data_valid_i low for 5 cycles in WAIT_PT -> data_ready_o stays 1, ena_reg_state_o=0, round_o is unchanged, and tag_valid_o is delayed by 5 cycles.
REQ-035 SHALL cover: resetb_i low during FINAL round 4 -> all outputs 0 immediately, IDLE, and a new start_i then gives nominal timing.
REQ-036 SHALL cover: start_i pulsed during PT -> ignored, and the cipher_valid_o count equals NB_BLOCKS.
